// File: rtl/cnn_pool_relu.sv
// Convolution / max-pool / ReLU PE array: OCP_NUM independent PEs, each with
// ICP_NUM private weight banks, a MAC accumulator and a running pooling maximum.
package cnn_pool_relu_pkg;
  localparam int DATA_WID  = 8;
  localparam int ICP_NUM   = 4;
  localparam int OCP_NUM   = 4;
  localparam int AUG_FCT_B = 4;
  localparam int ADDR_B    = 5;
  localparam int CAP_B     = 16;

  typedef enum logic [1:0] {
    INVALID  = 2'd0,
    CONV     = 2'd1,
    CONV_FIN = 2'd2,
    POOL_FIN = 2'd3
  } PE_STATE;

  typedef struct packed {
    PE_STATE                          PE_state;
    logic [ICP_NUM-1:0][DATA_WID-1:0] A;
    logic signed [DATA_WID-1:0]       wrb_data;
    logic [ICP_NUM-1:0]               wrb;
    logic [ADDR_B-1:0]                wrb_addr;
    logic [ADDR_B-1:0]                rdb_addr;
  } PE_IN_PACKET;

  typedef struct packed {
    logic [CAP_B-1:0] result;
    logic             valid;
  } PE_OUT_PACKET;
endpackage

// Packet struct widths come from the package; parameter overrides must match it.
module cnn_pool_relu #(
  parameter int DATA_WID  = cnn_pool_relu_pkg::DATA_WID,
  parameter int ICP_NUM   = cnn_pool_relu_pkg::ICP_NUM,
  parameter int OCP_NUM   = cnn_pool_relu_pkg::OCP_NUM,
  parameter int AUG_FCT_B = cnn_pool_relu_pkg::AUG_FCT_B,
  parameter int ADDR_B    = cnn_pool_relu_pkg::ADDR_B,
  parameter int CAP_B     = cnn_pool_relu_pkg::CAP_B
) (
  input  logic                           clk,
  input  logic                           reset,
  input  cnn_pool_relu_pkg::PE_IN_PACKET  CNN_pk_in [OCP_NUM],
  output cnn_pool_relu_pkg::PE_OUT_PACKET pk_out    [OCP_NUM]
);
  localparam int ACC_W = 2*DATA_WID + AUG_FCT_B;
  localparam int CW    = (ACC_W > CAP_B) ? ACC_W : CAP_B;
  localparam int DEPTH = 2**ADDR_B;
  localparam logic signed [ACC_W-1:0] MIN_NEG = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CW-1:0]           CAP_MAX = CW'({CAP_B{1'b1}});

  for (genvar i = 0; i < OCP_NUM; i++) begin : g_pe
    logic signed [DATA_WID-1:0]   w [ICP_NUM][DEPTH];
    logic signed [ACC_W-1:0]      acc, pmax, s, acc_s;
    logic signed [2*DATA_WID-1:0] prod;
    logic [CW-1:0]                relu_ext;
    logic [CAP_B-1:0]             result_q;
    logic                         valid_q;

    // Reads see the pre-edge bank contents, so a same-cycle write is not visible.
    always_comb begin
      s    = '0;
      prod = '0;
      for (int unsigned j = 0; j < ICP_NUM; j++) begin
        prod = $signed(CNN_pk_in[i].A[j]) * w[j][CNN_pk_in[i].rdb_addr];
        s    = s + {{AUG_FCT_B{prod[2*DATA_WID-1]}}, prod};
      end
      acc_s    = acc + s;
      relu_ext = pmax[ACC_W-1] ? '0 : CW'(pmax);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        acc      <= '0;
        pmax     <= MIN_NEG;
        result_q <= '0;
        valid_q  <= 1'b0;
        for (int unsigned j = 0; j < ICP_NUM; j++)
          for (int unsigned a = 0; a < DEPTH; a++)
            w[j][a] <= '0;
      end else begin
        for (int unsigned j = 0; j < ICP_NUM; j++)
          if (CNN_pk_in[i].wrb[j])
            w[j][CNN_pk_in[i].wrb_addr] <= CNN_pk_in[i].wrb_data;

        valid_q <= 1'b0;
        case (CNN_pk_in[i].PE_state)
          cnn_pool_relu_pkg::CONV: acc <= acc_s;
          cnn_pool_relu_pkg::CONV_FIN: begin
            if (acc_s > pmax) pmax <= acc_s;
            acc <= '0;
          end
          cnn_pool_relu_pkg::POOL_FIN: begin
            result_q <= (relu_ext > CAP_MAX) ? '1 : relu_ext[CAP_B-1:0];
            valid_q  <= 1'b1;
            pmax     <= MIN_NEG;
          end
          default: ;
        endcase
      end
    end

    assign pk_out[i].result = result_q;
    assign pk_out[i].valid  = valid_q;
  end
endmodule

// File: tb/tb_cnn_pool_relu.sv
// Bench for cnn_pool_relu: directed vector table, reset sequence, then
// randomized per-PE traffic against an integer reference model.
module tb_cnn_pool_relu;
  import cnn_pool_relu_pkg::*;

  localparam int NPE = OCP_NUM;
  localparam int NCH = ICP_NUM;
  localparam int DEP = 2**ADDR_B;
  localparam longint MIN_NEG = -(longint'(1) << (2*DATA_WID+AUG_FCT_B-1));
  localparam longint CAP_MAX = (longint'(1) << CAP_B) - 1;

  logic         clk = 1'b0;
  logic         reset;
  PE_IN_PACKET  pk_in  [NPE];
  PE_OUT_PACKET pk_out [NPE];

  int n_pass  = 0;
  int n_total = 0;

  cnn_pool_relu dut (
    .clk       (clk),
    .reset     (reset),
    .CNN_pk_in (pk_in),
    .pk_out    (pk_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    PE_STATE    st;
    int         a0, a1, a2, a3;
    logic [3:0] wrb;
    int         waddr, wdata, raddr;
    int         exp_res;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  int     mw   [NPE][NCH][DEP];
  longint macc [NPE];
  longint mpmax[NPE];
  int     mres [NPE];
  bit     mval [NPE];
  int     wcnt [NPE];

  function automatic vec_t mk(PE_STATE st, int a0, int a1, int a2, int a3,
                              logic [3:0] wrb, int waddr, int wdata, int raddr,
                              int exp_res, logic exp_valid);
    vec_t v;
    v.st = st; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.a3 = a3;
    v.wrb = wrb; v.waddr = waddr; v.wdata = wdata; v.raddr = raddr;
    v.exp_res = exp_res; v.exp_valid = exp_valid;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
  endtask

  task automatic check_all(input string tag, input int exp_res, input bit exp_valid);
    for (int p = 0; p < NPE; p++) begin
      chk($sformatf("%s result[%0d]", tag, p), int'(pk_out[p].result), exp_res);
      chk($sformatf("%s valid[%0d]", tag, p), int'(pk_out[p].valid), int'(exp_valid));
    end
  endtask

  task automatic drive_all(input vec_t v);
    for (int p = 0; p < NPE; p++) begin
      pk_in[p].PE_state = v.st;
      pk_in[p].A[0]     = DATA_WID'(v.a0);
      pk_in[p].A[1]     = DATA_WID'(v.a1);
      pk_in[p].A[2]     = DATA_WID'(v.a2);
      pk_in[p].A[3]     = DATA_WID'(v.a3);
      pk_in[p].wrb      = v.wrb;
      pk_in[p].wrb_addr = ADDR_B'(v.waddr);
      pk_in[p].wrb_data = DATA_WID'(v.wdata);
      pk_in[p].rdb_addr = ADDR_B'(v.raddr);
    end
  endtask

  task automatic step_vec(input string tag, input vec_t v);
    drive_all(v);
    @(posedge clk); #1;
    check_all(tag, v.exp_res, v.exp_valid);
  endtask

  function automatic int relu_sat(longint v);
    if (v < 0) return 0;
    if (v > CAP_MAX) return int'(CAP_MAX);
    return int'(v);
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NPE; p++) begin
      macc[p] = 0; mpmax[p] = MIN_NEG; mres[p] = 0; mval[p] = 0; wcnt[p] = 0;
      for (int j = 0; j < NCH; j++)
        for (int a = 0; a < DEP; a++) mw[p][j][a] = 0;
    end
  endtask

  task automatic model_step(input int p);
    longint s = 0;
    longint v;
    int ra = int'(pk_in[p].rdb_addr);
    for (int j = 0; j < NCH; j++)
      s += longint'($signed(pk_in[p].A[j])) * mw[p][j][ra];
    mval[p] = 0;
    case (pk_in[p].PE_state)
      CONV:     macc[p] += s;
      CONV_FIN: begin
        v = macc[p] + s;
        if (v > mpmax[p]) mpmax[p] = v;
        macc[p] = 0;
      end
      POOL_FIN: begin
        mres[p] = relu_sat(mpmax[p]);
        mval[p] = 1;
        mpmax[p] = MIN_NEG;
      end
      default: ;
    endcase
    for (int j = 0; j < NCH; j++)
      if (pk_in[p].wrb[j]) mw[p][j][int'(pk_in[p].wrb_addr)] = int'(pk_in[p].wrb_data);
  endtask

  initial begin
    vec_t idle;
    PE_STATE st;
    idle = mk(INVALID, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1'b0);

    // Directed table: each row is one cycle on all PEs; expectation is post-edge.
    vecs.push_back(mk(INVALID,  0, 0, 0, 0, 4'b1111, 1, 1, 0,     0, 0));
    vecs.push_back(mk(CONV_FIN, 1, 2, 3, 4, 4'b0000, 0, 0, 1,     0, 0));
    vecs.push_back(mk(POOL_FIN, 0, 0, 0, 0, 4'b0000, 0, 0, 1,    10, 1));
    vecs.push_back(mk(INVALID,  0, 0, 0, 0, 4'b0000, 0, 0, 1,    10, 0));
    vecs.push_back(mk(CONV,     1, 2, 3, 4, 4'b0000, 0, 0, 1,    10, 0));
    vecs.push_back(mk(CONV,     1, 2, 3, 4, 4'b0000, 0, 0, 1,    10, 0));
    vecs.push_back(mk(CONV_FIN, 1, 2, 3, 4, 4'b0000, 0, 0, 1,    10, 0));
    vecs.push_back(mk(POOL_FIN, 0, 0, 0, 0, 4'b0000, 0, 0, 1,    30, 1));
    vecs.push_back(mk(CONV_FIN, 1, 2, 3, 4, 4'b0000, 0, 0, 1,    30, 0));
    vecs.push_back(mk(CONV_FIN, 0, 1, 2, 3, 4'b0000, 0, 0, 1,    30, 0));
    vecs.push_back(mk(POOL_FIN, 0, 0, 0, 0, 4'b0000, 0, 0, 1,    10, 1));
    vecs.push_back(mk(POOL_FIN, 0, 0, 0, 0, 4'b0000, 0, 0, 1,     0, 1));
    vecs.push_back(mk(CONV_FIN, -1, -2, -3, -4, 4'b0000, 0, 0, 1, 0, 0));
    vecs.push_back(mk(POOL_FIN, 0, 0, 0, 0, 4'b0000, 0, 0, 1,     0, 1));
    vecs.push_back(mk(INVALID,  0, 0, 0, 0, 4'b1111, 2, 127, 0,   0, 0));
    vecs.push_back(mk(CONV,     127, 127, 127, 127, 4'b0000, 0, 0, 2, 0, 0));
    vecs.push_back(mk(CONV_FIN, 127, 127, 127, 127, 4'b0000, 0, 0, 2, 0, 0));
    vecs.push_back(mk(POOL_FIN, 0, 0, 0, 0, 4'b0000, 0, 0, 2, 65535, 1));
    vecs.push_back(mk(CONV_FIN, 1, 1, 1, 1, 4'b1111, 1, 5, 1, 65535, 0));
    vecs.push_back(mk(POOL_FIN, 0, 0, 0, 0, 4'b0000, 0, 0, 1,     4, 1));
    vecs.push_back(mk(CONV_FIN, 1, 1, 1, 1, 4'b0000, 0, 0, 1,     4, 0));
    vecs.push_back(mk(POOL_FIN, 0, 0, 0, 0, 4'b0000, 0, 0, 1,    20, 1));

    reset = 1'b1;
    drive_all(idle);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 1'b0);
    reset = 1'b0;

    for (int k = 0; k < vecs.size(); k++)
      step_vec($sformatf("vec%0d", k), vecs[k]);

    // Reset mid-window: accumulated state and weights are discarded.
    step_vec("rst_conv", mk(CONV, 1, 1, 1, 1, 4'b0000, 0, 0, 1, 20, 0));
    reset = 1'b1;
    step_vec("rst_cyc", mk(CONV_FIN, 1, 1, 1, 1, 4'b1111, 3, 9, 1, 0, 0));
    reset = 1'b0;
    step_vec("rst_pool", mk(POOL_FIN, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 0, 1));
    step_vec("rst_w2",   mk(CONV_FIN, 100, 100, 100, 100, 4'b0000, 0, 0, 2, 0, 0));
    step_vec("rst_w2p",  mk(POOL_FIN, 0, 0, 0, 0, 4'b0000, 0, 0, 2, 0, 1));
    step_vec("rst_w1",   mk(CONV_FIN, 50, 50, 50, 50, 4'b0000, 0, 0, 1, 0, 0));
    step_vec("rst_w1p",  mk(POOL_FIN, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 0, 1));

    // Randomized independent traffic per PE
    reset = 1'b1;
    drive_all(idle);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      reset = ($urandom_range(0, 99) < 2);
      for (int p = 0; p < NPE; p++) begin
        st = PE_STATE'($urandom_range(0, 3));
        if (st == CONV && wcnt[p] >= 2) st = CONV_FIN;
        pk_in[p].PE_state = st;
        for (int j = 0; j < NCH; j++) pk_in[p].A[j] = DATA_WID'($urandom);
        pk_in[p].wrb      = ($urandom_range(0, 9) < 4) ? NCH'($urandom) : '0;
        pk_in[p].wrb_addr = ADDR_B'($urandom_range(0, 3));
        pk_in[p].wrb_data = DATA_WID'($urandom);
        pk_in[p].rdb_addr = ($urandom_range(0, 9) < 8) ? ADDR_B'($urandom_range(0, 3))
                                                       : ADDR_B'($urandom);
      end
      if (reset) model_reset();
      else
        for (int p = 0; p < NPE; p++) begin
          if (pk_in[p].PE_state == CONV) wcnt[p]++;
          else if (pk_in[p].PE_state == CONV_FIN) wcnt[p] = 0;
          model_step(p);
        end
      @(posedge clk); #1;
      for (int p = 0; p < NPE; p++) begin
        chk($sformatf("rnd%0d result[%0d]", cyc, p), int'(pk_out[p].result), mres[p]);
        chk($sformatf("rnd%0d valid[%0d]", cyc, p), int'(pk_out[p].valid), int'(mval[p]));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
